button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions a raw mechanical push-button into clean, single-cycle events for the board-level control logic, such as the LED sequencers that take a `button` strobe. It synchronises the asynchronous pad input and filters contact bounce with a counter-based state machine. It then emits a debounced level plus one-cycle press, release and long-press pulses. One instance sits between each button pad and its consumer.

## Interface
- `DEBOUNCE_CYCLES`, default 32'd1_000_000: consecutive stable synchronised cycles required to accept a change (10 ms at 100 MHz). Legal range is 1 to 2^32-1.
- `LONG_CYCLES`, default 32'd100_000_000: cycles of debounced hold before `long_pulse` fires (1 s at 100 MHz). Legal range is 1 to 2^32-1.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, asynchronous and active-low. Asserting low clears all state immediately.
- `button_raw` input 1: pad input, asynchronous to `clk`, active-high (1 = pressed).
- `button_level` output 1: debounced button state.
- `press_pulse` output 1: one-cycle strobe when a press is accepted.
- `release_pulse` output 1: one-cycle strobe when a release is accepted.
- `long_pulse` output 1: one-cycle strobe, at most once per press, when the hold reaches `LONG_CYCLES`.

## Operation
- **Synchroniser.** `button_raw` passes through a two-flop synchroniser; `sync` is the second flop. No other logic samples `button_raw`.
- **FSM states:** RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
  - RELEASED, `sync`=1: go to PRESS_CHK and set `cnt`=0.
  - PRESS_CHK, `sync`=0: return to RELEASED. This is a bounce, so no pulse.
  - PRESS_CHK, `sync`=1, `cnt`<D-1: increment `cnt`.
  - PRESS_CHK, `sync`=1, `cnt`==D-1: go to PRESSED. Set `button_level`=1, `press_pulse`=1, `hold_cnt`=0, `long_done`=0.
  - PRESSED, `sync`=0: go to RELEASE_CHK and set `cnt`=0. `hold_cnt` freezes.
  - PRESSED, `sync`=1, `long_done`=0, `hold_cnt`==L-1: set `long_pulse`=1 and `long_done`=1.
  - PRESSED, `sync`=1, otherwise: increment `hold_cnt`, saturating once `long_done` is set.
  - RELEASE_CHK, `sync`=1: return to PRESSED. This is a bounce; `hold_cnt` resumes from its frozen value.
  - RELEASE_CHK, `sync`=0, `cnt`<D-1: increment `cnt`.
  - RELEASE_CHK, `sync`=0, `cnt`==D-1: go to RELEASED. Set `button_level`=0 and `release_pulse`=1.
- **Counter widths.** `cnt` and `hold_cnt` are 32 bits unsigned. Compares are equality only, and neither counter ever wraps.
- **Registered outputs.** All outputs are registered. Each pulse is high for exactly one cycle, and the pulses are mutually exclusive.
- **Reset mid-operation.** The block drops to RELEASED with all outputs 0 and no pulse emitted. If the button is still held after reset deassertion, the block treats it as a new press and fires `press_pulse` after the full debounce.

## Timing
- **Reset values.** `button_level`=0, `press_pulse`=0, `release_pulse`=0, `long_pulse`=0. Both synchroniser flops are 0, `cnt`=0, `hold_cnt`=0, `long_done`=0, state is RELEASED.
- **Press latency.** Let edge 1 be the first edge that samples `button_raw` high, with the input stable from then on. `press_pulse` and `button_level` are high after edge D+3: 2 synchroniser edges, 1 detect edge, then D check edges.
- **Release latency.** Symmetric to press: D+3 edges from the first edge sampling low.
- **Long press.** With `sync` held, `long_pulse` is high L edges after the edge that raised `press_pulse`.
- **Bounce width.** Any `sync` glitch shorter than D cycles produces no level change and no pulse.
- **D=1 case.** The press is accepted on the first PRESS_CHK cycle.

## Structure
- Shared package `board_pkg`:
  - FSM state enum (2-bit encoding: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3).
  - Counter width constant `CNT_W`=32.
  - Default cycle constants for 100 MHz.
- Sub-module `sync2`: a generic two-flop synchroniser using the same `clk` and active-low async `rst`, reset value 0. It will be reused for other pad inputs.

## Test plan
All scenarios use D=4 and L=10.
- **Reset values.** Hold `rst` low with `button_raw`=1 for 5 cycles, then check outputs. Response: all outputs are 0. Release `rst`; `press_pulse` is high for one cycle exactly D+3=7 edges later.
- **Clean press and hold.** Raise `button_raw` at edge 1 and hold it. Response: `press_pulse` is high after edge 7 and `button_level`=1 from then. `long_pulse` is high for one cycle after edge 17 and never again while held.
- **Press bounce.** Pattern 1,1,0,1,1,1,1,1,1 starting at edge 1. Response: no pulse before the pattern settles. `press_pulse` fires 7 edges after the final 0→1 transition is first sampled.
- **Short press release.** Hold for 12 cycles, then drop `button_raw` to 0. Response: `release_pulse` fires 7 edges after the drop, `button_level`=0, and no `long_pulse` ever occurs.
- **Release bounce inside PRESSED.** While held, inject a 2-cycle low glitch. Response: no `release_pulse`, `button_level` stays 1, and `long_pulse` timing shifts by the frozen cycles only.
- **Reset mid-hold.** Pulse `rst` low for 1 cycle during PRESSED. Response: `button_level` drops to 0 immediately (async) with no `release_pulse`. A fresh `press_pulse` follows D+3 edges after reset deassertion, since the button is still held.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for board-level button conditioning.
// State encoding, counter width and 100 MHz default timings.
package board_pkg;

    localparam int CNT_W = 32;

    // 10 ms and 1 s at a 100 MHz system clock
    localparam logic [CNT_W-1:0] DEF_DEBOUNCE_CYCLES = 32'd1_000_000;
    localparam logic [CNT_W-1:0] DEF_LONG_CYCLES     = 32'd100_000_000;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } btn_state_e;

    // Terminal count of an n-cycle window; n is never 0
    function automatic logic [CNT_W-1:0] last_cnt(
        input logic [CNT_W-1:0] n
    );
        return n - 32'd1;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Pad-to-consumer bundle for one debounced push-button.
// master is the board side, slave is the debouncer.
interface button_debouncer_if;

    logic button_raw;
    logic button_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport master (
        output button_raw,
        input  button_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  button_raw,
        output button_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );

endinterface

// File: rtl/button_debouncer_sync2.sv
// Generic two-flop synchroniser for asynchronous pad inputs.
// Both stages clear to 0 on the active-low async reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // first stage may go metastable; second stage is the clean copy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronise, filter bounce, then emit
// a clean level plus press, release and long-press strobes.
module button_debouncer
    import board_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CNT_W-1:0] LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    button_debouncer_if.slave btn
);

    localparam logic [CNT_W-1:0] D_LAST = last_cnt(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] L_LAST = last_cnt(LONG_CYCLES);

    logic sync;

    btn_state_e state_q;
    btn_state_e state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;

    logic long_done_q;
    logic long_done_d;
    logic level_q;
    logic level_d;
    logic press_q;
    logic press_d;
    logic release_q;
    logic release_d;
    logic long_q;
    logic long_d;

    sync2 #(
        .W (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn.button_raw),
        .q_o (sync)
    );

    // next-state: pulses default low, counters hold unless stepped
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        unique case (state_q)
            ST_RELEASED: begin
                if (sync) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end

            ST_PRESS_CHK: begin
                if (!sync) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q == D_LAST) begin
                    state_d     = ST_PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_PRESSED: begin
                if (!sync) begin
                    // hold_q is left alone so a bounce resumes it
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = '0;
                end else if (!long_done_q) begin
                    if (hold_q == L_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 32'd1;
                    end
                end
            end

            ST_RELEASE_CHK: begin
                if (sync) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == D_LAST) begin
                    state_d   = ST_RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_RELEASED;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RELEASED;
            cnt_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign btn.button_level  = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.long_pulse    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer.
// Reference model: run lengths of the synchronised input.
module tb_button_debouncer;
    import board_pkg::*;

    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    button_debouncer_if bif ();

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES (32'd4),
        .LONG_CYCLES     (32'd10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (bif)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic m_s0 = 1'b0;
    logic m_s1 = 1'b0;
    logic m_lvl = 1'b0;
    logic m_pp = 1'b0;
    logic m_rp = 1'b0;
    logic m_lp = 1'b0;
    logic m_ld = 1'b0;
    int   m_run = 0;
    int   m_hold = 0;
    int   edge_n = 0;

    task automatic model_clear();
        m_s0 = 0; m_s1 = 0; m_lvl = 0;
        m_pp = 0; m_rp = 0; m_lp = 0; m_ld = 0;
        m_run = 0; m_hold = 0;
    endtask

    // a change is accepted after D+1 consecutive edges where the
    // synchronised input disagrees with the level; hold time counts
    // only edges with the input high and no release check pending
    task automatic model_step();
        logic s;
        s = m_s1;
        m_pp = 0; m_rp = 0; m_lp = 0;
        if (s != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
                m_lvl = s;
                m_run = 0;
                if (s) begin
                    m_pp = 1; m_hold = 0; m_ld = 0;
                end else begin
                    m_rp = 1;
                end
            end
        end else begin
            if (m_lvl && m_run == 0 && !m_ld) begin
                m_hold++;
                if (m_hold == L) begin
                    m_lp = 1; m_ld = 1;
                end
            end
            m_run = 0;
        end
        m_s1 = m_s0;
        m_s0 = bif.button_raw;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_clear();
        else begin
            model_step();
            edge_n++;
        end
    end

    // observation window for directed latency checks
    int mark = 0;
    int p_first = 0, r_first = 0, l_first = 0;
    int p_cnt = 0, r_cnt = 0, l_cnt = 0;

    task automatic mark_obs();
        mark = edge_n;
        p_first = 0; r_first = 0; l_first = 0;
        p_cnt = 0; r_cnt = 0; l_cnt = 0;
    endtask

    initial forever begin
        @(negedge clk);
        chk("level", int'(bif.button_level), int'(m_lvl));
        chk("press", int'(bif.press_pulse), int'(m_pp));
        chk("release", int'(bif.release_pulse), int'(m_rp));
        chk("long", int'(bif.long_pulse), int'(m_lp));
        if (bif.press_pulse) begin
            p_cnt++;
            if (p_first == 0) p_first = edge_n - mark;
        end
        if (bif.release_pulse) begin
            r_cnt++;
            if (r_first == 0) r_first = edge_n - mark;
        end
        if (bif.long_pulse) begin
            l_cnt++;
            if (l_first == 0) l_first = edge_n - mark;
        end
    end

    task automatic tick(input logic v);
        @(negedge clk);
        bif.button_raw = v;
    endtask

    task automatic rst_assert();
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic rst_release();
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        logic [8:0] pat;
        int len;
        logic v;

        // reset held with the button pressed
        bif.button_raw = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_level", int'(bif.button_level), 0);
        chk("rst_press", int'(bif.press_pulse), 0);
        chk("rst_release", int'(bif.release_pulse), 0);
        chk("rst_long", int'(bif.long_pulse), 0);
        rst_release();
        mark_obs();
        repeat (12) tick(1'b1);
        chk("rst_press_lat", p_first, D + 3);
        chk("rst_press_cnt", p_cnt, 1);
        tick(1'b0);
        mark_obs();
        repeat (12) tick(1'b0);
        chk("rst_rel_lat", r_first, D + 3);

        // clean press and long hold
        tick(1'b1);
        mark_obs();
        repeat (39) tick(1'b1);
        chk("clean_press_lat", p_first, D + 3);
        chk("clean_long_lat", l_first, D + 3 + L);
        chk("clean_long_cnt", l_cnt, 1);
        chk("clean_level", int'(bif.button_level), 1);
        tick(1'b0);
        mark_obs();
        repeat (12) tick(1'b0);
        chk("clean_rel_lat", r_first, D + 3);
        chk("clean_rel_cnt", r_cnt, 1);

        // press bounce: last 0->1 is sampled at edge 4
        pat = 9'b111111011;
        tick(pat[0]);
        mark_obs();
        for (int i = 1; i < 9; i++) tick(pat[i]);
        repeat (10) tick(1'b1);
        chk("bounce_press_lat", p_first, 4 + D + 2);
        chk("bounce_press_cnt", p_cnt, 1);
        repeat (16) tick(1'b0);

        // short press then release
        tick(1'b1);
        mark_obs();
        repeat (11) tick(1'b1);
        chk("short_press_lat", p_first, D + 3);
        chk("short_long_hold", l_cnt, 0);
        tick(1'b0);
        mark_obs();
        repeat (14) tick(1'b0);
        chk("short_rel_lat", r_first, D + 3);
        chk("short_long_rel", l_cnt, 0);
        chk("short_level", int'(bif.button_level), 0);

        // 2-cycle low glitch at edges 10,11 freezes hold for 3 edges
        tick(1'b1);
        mark_obs();
        for (int i = 2; i <= 30; i++) tick((i == 10 || i == 11) ? 1'b0 : 1'b1);
        chk("glitch_long_lat", l_first, D + 3 + L + 3);
        chk("glitch_long_cnt", l_cnt, 1);
        chk("glitch_rel_cnt", r_cnt, 0);
        chk("glitch_level", int'(bif.button_level), 1);

        // reset mid-hold: level drops at once, fresh press follows
        mark_obs();
        rst_assert();
        #1;
        chk("mid_rst_level", int'(bif.button_level), 0);
        chk("mid_rst_release", int'(bif.release_pulse), 0);
        rst_release();
        chk("mid_rst_rel_cnt", r_cnt, 0);
        mark_obs();
        repeat (12) tick(1'b1);
        chk("mid_rst_press_lat", p_first, D + 3);
        chk("mid_rst_rel_cnt2", r_cnt, 0);

        // random runs with occasional resets, model-checked each cycle
        for (int s = 0; s < 250; s++) begin
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            repeat (len) tick(v);
            if ($urandom_range(0, 39) == 0) begin
                rst_assert();
                rst_release();
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
